// File: rtl/i2s_pkg.sv
// Shared constants and state type for the I2S transmit framer.
// Default geometry: 16-bit samples in 32-slot channels, 6 clk per SCLK.
package i2s_pkg;

  localparam int I2S_DW          = 16;
  localparam int I2S_BITS_PER_CH = 32;
  localparam int I2S_SCLK_DIV    = 6;
  localparam int I2S_FRAME_CLKS  = 2 * I2S_BITS_PER_CH * I2S_SCLK_DIV;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } i2s_state_t;

endpackage

// File: rtl/i2s_bit_timer.sv
// SCLK divider and frame slot counter for the I2S framer; produces SCLK level,
// LRCK level, per-channel slot index and the fall/rise/frame-last strobes.
module i2s_bit_timer
  import i2s_pkg::*;
#(
  parameter int BITS_PER_CH = I2S_BITS_PER_CH,
  parameter int SCLK_DIV    = I2S_SCLK_DIV,
  localparam int DIV_W      = $clog2(SCLK_DIV),
  localparam int SLOT_W     = $clog2(2 * BITS_PER_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              run,
  output logic              sclk_lvl,
  output logic              lrck_lvl,
  output logic              fall_stb,
  output logic              rise_stb,
  output logic              frame_last,
  output logic [SLOT_W-1:0] chan_slot
);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(SCLK_DIV / 2);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(2 * BITS_PER_CH - 1);
  localparam logic [SLOT_W-1:0] SLOT_HALF = SLOT_W'(BITS_PER_CH);

  logic [DIV_W-1:0]  div_cnt_r;
  logic [SLOT_W-1:0] slot_r;

  // Divider and slot counters: zeroed on start and held at zero outside a frame.
  always_ff @(posedge clk) begin
    if (reset || start || !run) begin
      div_cnt_r <= '0;
      slot_r    <= '0;
    end else if (div_cnt_r == DIV_LAST) begin
      div_cnt_r <= '0;
      slot_r    <= (slot_r == SLOT_LAST) ? '0 : slot_r + SLOT_W'(1);
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
      slot_r    <= slot_r;
    end
  end

  assign lrck_lvl   = run && (slot_r >= SLOT_HALF);
  assign chan_slot  = lrck_lvl ? (slot_r - SLOT_HALF) : slot_r;
  assign sclk_lvl   = run && (div_cnt_r >= DIV_HALF);
  assign fall_stb   = run && (div_cnt_r == DIV_W'(0));
  assign rise_stb   = run && (div_cnt_r == DIV_HALF);
  assign frame_last = run && (div_cnt_r == DIV_LAST) && (slot_r == SLOT_LAST);

endmodule

// File: rtl/i2s_tx_framer.sv
// Stereo I2S serializer: latches a sample pair on each rate strobe and sends one frame.
// Optional receive path (SDIN deserializer) is built when I2S_RX_EN is defined.
module i2s_tx_framer
  import i2s_pkg::*;
#(
  parameter int DW          = I2S_DW,
  parameter int BITS_PER_CH = I2S_BITS_PER_CH,
  parameter int SCLK_DIV    = I2S_SCLK_DIV
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rate,
  input  logic [DW-1:0] l_in,
  input  logic [DW-1:0] r_in,
  output logic          sclk,
  output logic          lrck,
  output logic          sdout,
  input  logic          sdin,
  output logic [DW-1:0] l_out,
  output logic [DW-1:0] r_out,
  output logic          rx_valid,
  output logic          busy
);

  localparam int SLOT_W = $clog2(2 * BITS_PER_CH);

  i2s_state_t        state_r, state_next_s;
  logic              run_s, sclk_s, lrck_s, fall_s, rise_s, frame_last_s;
  logic [SLOT_W-1:0] k_s;
  logic [DW-1:0]     l_hold_r, r_hold_r, tx_sh_r;
  logic              sclk_r, lrck_r, sdout_r, busy_r;

  assign run_s = (state_r == RUN);

  i2s_bit_timer #(
    .BITS_PER_CH (BITS_PER_CH),
    .SCLK_DIV    (SCLK_DIV)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .start      (rate),
    .run        (run_s),
    .sclk_lvl   (sclk_s),
    .lrck_lvl   (lrck_s),
    .fall_stb   (fall_s),
    .rise_stb   (rise_s),
    .frame_last (frame_last_s),
    .chan_slot  (k_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state: rate always (re)starts a frame, the final clock of slot 63 ends it.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (rate) state_next_s = RUN;
        else      state_next_s = IDLE;
      end
      RUN: begin
        if (rate)              state_next_s = RUN;
        else if (frame_last_s) state_next_s = IDLE;
        else                   state_next_s = RUN;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Sample holding registers and TX shifter, reloaded at slot 0 of each channel.
  always_ff @(posedge clk) begin
    if (reset) begin
      l_hold_r <= '0;
      r_hold_r <= '0;
      tx_sh_r  <= '0;
    end else begin
      if (rate) begin
        l_hold_r <= l_in;
        r_hold_r <= r_in;
      end else begin
        l_hold_r <= l_hold_r;
        r_hold_r <= r_hold_r;
      end
      if (fall_s) begin
        if (k_s == SLOT_W'(0)) tx_sh_r <= lrck_s ? r_hold_r : l_hold_r;
        else                   tx_sh_r <= tx_sh_r << 1'b1;
      end else begin
        tx_sh_r <= tx_sh_r;
      end
    end
  end

  // Registered I2S pins; SDOUT moves only on the SCLK falling edge (div_cnt = 0).
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r  <= 1'b0;
      sclk_r  <= 1'b0;
      lrck_r  <= 1'b0;
      sdout_r <= 1'b0;
    end else begin
      busy_r <= run_s;
      sclk_r <= sclk_s;
      lrck_r <= lrck_s;
      if (!run_s)      sdout_r <= 1'b0;
      else if (fall_s) sdout_r <= (k_s == SLOT_W'(0)) ? 1'b0 : tx_sh_r[DW-1];
      else             sdout_r <= sdout_r;
    end
  end

  assign busy  = busy_r;
  assign sclk  = sclk_r;
  assign lrck  = lrck_r;
  assign sdout = sdout_r;

`ifdef I2S_RX_EN
  logic [DW-1:0] rx_l_r, rx_r_r, l_out_r, r_out_r;
  logic          rx_valid_r, rx_bit_s;

  assign rx_bit_s = rise_s && (k_s >= SLOT_W'(1)) && (k_s <= SLOT_W'(DW));

  // Deserialize SDIN on SCLK rise; publish the pair on the last clock of the frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_l_r     <= '0;
      rx_r_r     <= '0;
      l_out_r    <= '0;
      r_out_r    <= '0;
      rx_valid_r <= 1'b0;
    end else begin
      if (frame_last_s) begin
        l_out_r    <= rx_l_r;
        r_out_r    <= rx_r_r;
        rx_valid_r <= 1'b1;
      end else begin
        l_out_r    <= l_out_r;
        r_out_r    <= r_out_r;
        rx_valid_r <= 1'b0;
      end
      if (rate) begin
        rx_l_r <= '0;
        rx_r_r <= '0;
      end else if (rx_bit_s) begin
        if (lrck_s) begin
          rx_l_r <= rx_l_r;
          rx_r_r <= (rx_r_r << 1'b1) | DW'(sdin);
        end else begin
          rx_l_r <= (rx_l_r << 1'b1) | DW'(sdin);
          rx_r_r <= rx_r_r;
        end
      end else begin
        rx_l_r <= rx_l_r;
        rx_r_r <= rx_r_r;
      end
    end
  end

  assign l_out    = l_out_r;
  assign r_out    = r_out_r;
  assign rx_valid = rx_valid_r;
`else
  logic unused_rx_s;

  assign unused_rx_s = ^{sdin, rise_s};
  assign l_out       = '0;
  assign r_out       = '0;
  assign rx_valid    = 1'b0;
`endif

endmodule
